// File: rtl/mem_wb_stage.sv
// M->W pipeline register with load byte/halfword extraction, misalignment
// detection and write-back source selection for the GRF write port.
module mem_wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic [DW-1:0] pc_M,
  input  logic [DW-1:0] alu_M,
  input  logic [DW-1:0] dm_rdata_M,
  input  logic [4:0]    a3_M,
  input  logic          regwrite_M,
  input  logic [1:0]    wdsel_M,
  input  logic [2:0]    ldtype_M,
  output logic [DW-1:0] pc_W,
  output logic [4:0]    a3_W,
  output logic          regwrite_W,
  output logic [DW-1:0] wd_W,
  output logic          misalign_W
);

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_MEM  = 2'b01,
    WD_PC8  = 2'b10,
    WD_RSVD = 2'b11
  } wdsel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_BU = 3'b001,
    LD_B  = 3'b010,
    LD_HU = 3'b011,
    LD_H  = 3'b100
  } ldtype_e;

  logic [DW-1:0] pc_q,       pc_d;
  logic [DW-1:0] alu_q,      alu_d;
  logic [DW-1:0] rdata_q,    rdata_d;
  logic [4:0]    a3_q,       a3_d;
  logic          regwrite_q, regwrite_d;
  logic [1:0]    wdsel_q,    wdsel_d;
  logic [2:0]    ldtype_q,   ldtype_d;

  // Next-state selection: reset > flush > en > hold.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    pc_d       = pc_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    a3_d       = a3_q;
    regwrite_d = regwrite_q;
    wdsel_d    = wdsel_q;
    ldtype_d   = ldtype_q;
    if (reset || flush) begin
      pc_d       = PC_RESET;
      alu_d      = '0;
      rdata_d    = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      wdsel_d    = '0;
      ldtype_d   = '0;
    end else if (en) begin
      pc_d       = pc_M;
      alu_d      = alu_M;
      rdata_d    = dm_rdata_M;
      a3_d       = a3_M;
      regwrite_d = regwrite_M;
      wdsel_d    = wdsel_M;
      ldtype_d   = ldtype_M;
    end
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples its _d value from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    alu_q      <= alu_d;
    rdata_q    <= rdata_d;
    a3_q       <= a3_d;
    regwrite_q <= regwrite_d;
    wdsel_q    <= wdsel_d;
    ldtype_q   <= ldtype_d;
  end

  logic [1:0]    off;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_val;
  logic          misalign;
  logic [DW-1:0] wd_raw;
  logic          wr_en;

  assign off      = alu_q[1:0];
  assign half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (off)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
  end

  // Undefined load types behave as lw, both for data and alignment.
  always_comb begin
    load_val = rdata_q;
    case (ldtype_q)
      LD_BU:   load_val = {{(DW-8){1'b0}}, byte_sel};
      LD_B:    load_val = {{(DW-8){byte_sel[7]}}, byte_sel};
      LD_HU:   load_val = {{(DW-16){1'b0}}, half_sel};
      LD_H:    load_val = {{(DW-16){half_sel[15]}}, half_sel};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (wdsel_q == WD_MEM) begin
      case (ldtype_q)
        LD_BU, LD_B: misalign = 1'b0;
        LD_HU, LD_H: misalign = off[0];
        default:     misalign = (off != 2'b00);
      endcase
    end
  end

  always_comb begin
    wd_raw = alu_q;
    case (wdsel_q)
      WD_MEM:  wd_raw = load_val;
      WD_PC8:  wd_raw = pc_q + DW'(8);
      default: wd_raw = alu_q;
    endcase
  end

  // Zeroing wd_W for non-writes keeps forwarding comparators from matching stale data.
  assign wr_en = regwrite_q && (a3_q != 5'd0) && !misalign;

  assign pc_W       = pc_q;
  assign a3_W       = a3_q;
  assign regwrite_W = wr_en;
  assign wd_W       = wr_en ? wd_raw : '0;
  assign misalign_W = misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a behavioural model predicts each W
// state, a separate monitor compares the DUT one cycle after capture.
module tb_mem_wb_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] pc_M, alu_M, dm_rdata_M;
  logic [4:0]  a3_M;
  logic        regwrite_M;
  logic [1:0]  wdsel_M;
  logic [2:0]  ldtype_M;
  logic [31:0] pc_W, wd_W;
  logic [4:0]  a3_W;
  logic        regwrite_W, misalign_W;

  always #5 clk = ~clk;

  mem_wb_stage #(.PC_RESET(PC_RESET), .DW(32)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .pc_M(pc_M), .alu_M(alu_M), .dm_rdata_M(dm_rdata_M),
    .a3_M(a3_M), .regwrite_M(regwrite_M), .wdsel_M(wdsel_M), .ldtype_M(ldtype_M),
    .pc_W(pc_W), .a3_W(a3_W), .regwrite_W(regwrite_W),
    .wd_W(wd_W), .misalign_W(misalign_W)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        rw;
    logic [31:0] wd;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t model_state;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference model: what the write port should show for one instruction.
  function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] alu,
                                   input logic [31:0] rdata, input logic [4:0] a3,
                                   input logic rw, input logic [1:0] wdsel,
                                   input logic [2:0] ldtype, input string tag);
    exp_t        e;
    int unsigned off, b, h;
    logic [31:0] value;
    logic        mis;
    off = alu % 4;
    b   = (rdata >> (8 * off)) % 256;
    h   = (off >= 2) ? rdata / 65536 : rdata % 65536;
    mis = 1'b0;
    case (ldtype)
      3'd1: value = b;
      3'd2: value = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd3: begin value = h; mis = (off % 2) != 0; end
      3'd4: begin value = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h); mis = (off % 2) != 0; end
      default: begin value = rdata; mis = off != 0; end
    endcase
    if (wdsel != 2'd1) mis = 1'b0;
    e.pc  = pc;
    e.a3  = a3;
    e.mis = mis;
    e.rw  = rw && (a3 != 0) && !mis;
    if (!e.rw) e.wd = 32'd0;
    else if (wdsel == 2'd1) e.wd = value;
    else if (wdsel == 2'd2) e.wd = pc + 32'd8;
    else e.wd = alu;
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t nop_state(input string tag);
    exp_t e;
    e.pc = PC_RESET; e.a3 = 0; e.rw = 0; e.wd = 0; e.mis = 0; e.tag = tag;
    return e;
  endfunction

  // Drive one M-stage cycle and push the W state expected after the next edge.
  task automatic drive(input string tag, input logic rst, input logic fl, input logic e_n,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] a3, input logic rw, input logic [1:0] wdsel,
                       input logic [2:0] ldtype);
    @(negedge clk);
    #1;
    reset = rst; flush = fl; en = e_n;
    pc_M = pc; alu_M = alu; dm_rdata_M = rdata;
    a3_M = a3; regwrite_M = rw; wdsel_M = wdsel; ldtype_M = ldtype;
    if (rst || fl) model_state = nop_state(tag);
    else if (e_n) model_state = predict(pc, alu, rdata, a3, rw, wdsel, ldtype, tag);
    else model_state.tag = tag;
    exp_q.push_back(model_state);
  endtask

  // Monitor: W registers change only at the edge, so compare just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".pc_W"},       pc_W,               e.pc);
      check({e.tag, ".a3_W"},       {27'd0, a3_W},      {27'd0, e.a3});
      check({e.tag, ".regwrite_W"}, {31'd0, regwrite_W}, {31'd0, e.rw});
      check({e.tag, ".wd_W"},       wd_W,               e.wd);
      check({e.tag, ".misalign_W"}, {31'd0, misalign_W}, {31'd0, e.mis});
    end
  end

  initial begin
    reset = 1; flush = 0; en = 0;
    pc_M = 0; alu_M = 0; dm_rdata_M = 0; a3_M = 0; regwrite_M = 0; wdsel_M = 0; ldtype_M = 0;
    model_state = nop_state("init");

    // Reset held while an lw sits in M, then released.
    drive("rst0",  1, 0, 1, 32'h0000_3000, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4, 1, 2'd1, 3'd0);
    drive("rst1",  1, 0, 1, 32'h0000_3000, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4, 1, 2'd1, 3'd0);
    drive("lw",    0, 0, 1, 32'h0000_3000, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4, 1, 2'd1, 3'd0);
    // Byte and halfword extraction.
    drive("lb",    0, 0, 1, 32'h0000_3004, 32'h0000_0013, 32'h80FF_7F01, 5'd8, 1, 2'd1, 3'd2);
    drive("lbu",   0, 0, 1, 32'h0000_3008, 32'h0000_0013, 32'h80FF_7F01, 5'd8, 1, 2'd1, 3'd1);
    drive("lh",    0, 0, 1, 32'h0000_300C, 32'h0000_0012, 32'h8001_1234, 5'd9, 1, 2'd1, 3'd4);
    drive("lhu",   0, 0, 1, 32'h0000_3010, 32'h0000_0010, 32'h8001_1234, 5'd9, 1, 2'd1, 3'd3);
    // Misaligned lw and lh.
    drive("lwmis", 0, 0, 1, 32'h0000_3014, 32'h0000_0006, 32'h1234_5678, 5'd3, 1, 2'd1, 3'd0);
    drive("lhmis", 0, 0, 1, 32'h0000_3018, 32'h0000_0001, 32'h1234_5678, 5'd3, 1, 2'd1, 3'd4);
    // jal link value, $0 destination, PC wrap.
    drive("jal",   0, 0, 1, 32'h0000_3010, 32'h0000_0000, 32'h0,        5'd31, 1, 2'd2, 3'd0);
    drive("jal0",  0, 0, 1, 32'h0000_3010, 32'h0000_0000, 32'h0,        5'd0,  1, 2'd2, 3'd0);
    drive("jalwr", 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0,        5'd31, 1, 2'd2, 3'd0);
    drive("alu",   0, 0, 1, 32'h0000_3020, 32'hCAFE_0001, 32'h0,        5'd5,  1, 2'd0, 3'd0);
    drive("rsvd",  0, 0, 1, 32'h0000_3024, 32'h1357_9BDF, 32'hFFFF_FFFF, 5'd6, 1, 2'd3, 3'd0);
    // Stall three cycles with changing M inputs, then flush while stalled.
    for (int i = 0; i < 3; i++)
      drive("stall", 0, 0, 0, $urandom, $urandom, $urandom, 5'($urandom), 1, 2'($urandom), 3'($urandom));
    drive("flush_hold", 0, 1, 0, 32'h0000_4000, 32'h4, 32'h1, 5'd7, 1, 2'd0, 3'd0);
    drive("after_flush", 0, 0, 1, 32'h0000_4004, 32'h8, 32'h1, 5'd7, 1, 2'd0, 3'd0);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
      drive("rand",
            $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
            pc, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
            2'($urandom), 3'($urandom_range(0, 7)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
